mc_control_fsm: RTL and testbench

- Main control state machine for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over shared PC/IR/ALUOut registers and a single ALU.
- Produces the alu_op/is_imm pair that the ALU decoder consumes.
- Handles a ready-based handshake with the unified instruction/data memory port.

---
 rtl/mc_control_fsm.sv | 128 ++++++++++++
 tb/tb_mc_control_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional macro MC_CTRL_TRAP_EN: unknown opcodes park the FSM in TRAP with illegal=1 until reset.
module mc_control_fsm #(
    parameter int OPC_W   = 7,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_op,
    output logic               is_imm,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH,
        S_JAL, S_JALR_ADR, S_TRAP
    } state_t;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    state_t state;

    // NOTE: sequential state is updated only with <=, so every read in this block sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            unique case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    unique case (opcode)
                        OPC_LOAD, OPC_STORE: state <= S_MEMADR;
                        OPC_OP:              state <= S_EXEC_R;
                        OPC_OP_IMM:          state <= S_EXEC_I;
                        OPC_BRANCH:          state <= S_BRANCH;
                        OPC_JAL:             state <= S_JAL;
                        OPC_JALR:            state <= S_JALR_ADR;
                        OPC_LUI:             state <= S_LUI;
                        OPC_AUIPC:           state <= S_AUIPC;
`ifdef MC_CTRL_TRAP_EN
                        default:             state <= S_TRAP;
`else
                        default:             state <= S_FETCH;
`endif
                    endcase
                end
                S_MEMADR:   state <= (opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state <= S_ALUWB;
                // JALR only differs from JAL in the target computation, so it joins the JAL path.
                S_JALR_ADR: state <= S_JAL;
                S_JAL:      state <= S_ALUWB;
`ifdef MC_CTRL_TRAP_EN
                S_TRAP:     state <= S_TRAP;
`endif
                default:    state <= S_FETCH;
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 2'b00;
        is_imm     = 1'b0;
        illegal    = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
            S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
            S_MEMREAD:  begin mem_req = 1'b1; adr_src = 1'b1; end
            S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
            S_MEMWRITE: begin mem_req = 1'b1; mem_write = 1'b1; adr_src = 1'b1; end
            S_EXEC_R:   begin alu_src_a = 2'b10; alu_op = 2'b10; end
            S_EXEC_I:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; is_imm = 1'b1; end
            S_LUI:      begin alu_src_a = 2'b11; alu_src_b = 2'b01; end
            S_AUIPC:    begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH:   begin alu_src_a = 2'b10; alu_op = 2'b01; pc_write = alu_zero; end
            S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
            S_JALR_ADR: begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
`ifdef MC_CTRL_TRAP_EN
            S_TRAP:     illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm: a per-instruction state-path model plus directed literal checks.
module tb_mc_control_fsm;
    localparam int OPC_W   = 7;
    localparam int STATE_W = 4;

    // State numbering exposed on state_dbg, in the order the states are listed for the block.
    typedef enum int {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH,
        S_JAL, S_JALR_ADR, S_TRAP
    } st_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [OPC_W-1:0]   opcode = '0;
    logic               alu_zero = 1'b0;
    logic               mem_ready = 1'b0;
    logic               mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]         alu_src_a, alu_src_b, result_src, alu_op;
    logic               is_imm, illegal;
    logic [STATE_W-1:0] state_dbg;

    mc_control_fsm #(.OPC_W(OPC_W), .STATE_W(STATE_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_op(alu_op), .is_imm(is_imm),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    st_t  m_state = S_FETCH;
    st_t  path[$];
    logic [6:0] next_opc = 7'b0110011;
    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (model state %0d)", name, got, exp, $time, m_state);
        end
    endtask

    // Expected output vector for a state, read off the per-state output table.
    function automatic logic [15:0] exp_vec(st_t s, logic rdy, logic zr);
        logic req = 0, wr = 0, adr = 0, irw = 0, pcw = 0, rw = 0, imm = 0, ill = 0;
        logic [1:0] a = 0, b = 0, rs = 0, op = 0;
        case (s)
            S_FETCH:    begin req = 1; b = 2; rs = 2; irw = rdy; pcw = rdy; end
            S_DECODE:   begin a = 1; b = 1; end
            S_MEMADR:   begin a = 2; b = 1; end
            S_MEMREAD:  begin req = 1; adr = 1; end
            S_MEMWB:    begin rs = 1; rw = 1; end
            S_MEMWRITE: begin req = 1; wr = 1; adr = 1; end
            S_EXEC_R:   begin a = 2; op = 2; end
            S_EXEC_I:   begin a = 2; b = 1; op = 2; imm = 1; end
            S_LUI:      begin a = 3; b = 1; end
            S_AUIPC:    begin a = 1; b = 1; end
            S_ALUWB:    rw = 1;
            S_BRANCH:   begin a = 2; op = 1; pcw = zr; end
            S_JAL:      begin a = 1; b = 2; pcw = 1; end
            S_JALR_ADR: begin a = 2; b = 1; end
            S_TRAP:     ill = 1;
            default: ;
        endcase
        return {req, wr, adr, irw, pcw, rw, a, b, rs, op, imm, ill};
    endfunction

    function automatic logic [15:0] got_vec();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_op, is_imm, illegal};
    endfunction

    // Remaining states an instruction visits after DECODE; FETCH follows once the list is empty.
    function automatic void route(logic [6:0] opc);
        path.delete();
        case (opc)
            7'b0000011: path = '{S_MEMADR, S_MEMREAD, S_MEMWB};
            7'b0100011: path = '{S_MEMADR, S_MEMWRITE};
            7'b0110011: path = '{S_EXEC_R, S_ALUWB};
            7'b0010011: path = '{S_EXEC_I, S_ALUWB};
            7'b1100011: path = '{S_BRANCH};
            7'b1101111: path = '{S_JAL, S_ALUWB};
            7'b1100111: path = '{S_JALR_ADR, S_JAL, S_ALUWB};
            7'b0110111: path = '{S_LUI, S_ALUWB};
            7'b0010111: path = '{S_AUIPC, S_ALUWB};
`ifdef MC_CTRL_TRAP_EN
            default:    path = '{S_TRAP};
`else
            default: ;
`endif
        endcase
    endfunction

    function automatic void next_from_path();
        if (path.size() > 0) m_state = path.pop_front();
        else                 m_state = S_FETCH;
    endfunction

    // One clock: drive at negedge, compare 1 ns later, advance the model. Returns before the next posedge.
    task automatic step(input logic rdy, input logic zr);
        @(negedge clk);
        mem_ready = rdy;
        alu_zero  = zr;
        if (m_state == S_FETCH) opcode = next_opc;
        #1;
        check("outputs", 32'(got_vec()), 32'(exp_vec(m_state, rdy, zr)));
        check("state_dbg", 32'(state_dbg), 32'(m_state));
        case (m_state)
            S_FETCH:              if (rdy) m_state = S_DECODE;
            S_DECODE:             begin route(opcode); next_from_path(); end
            S_MEMREAD, S_MEMWRITE: if (rdy) next_from_path();
            S_TRAP: ;
            default:              next_from_path();
        endcase
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        m_state = S_FETCH;
        path.delete();
        #1;
        check("reset_outputs", 32'(got_vec()), 32'(exp_vec(S_FETCH, 1'b0, alu_zero)));
        repeat (cycles) begin
            @(negedge clk);
            #1;
            check("reset_hold_state", 32'(state_dbg), 32'(S_FETCH));
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int trap_cnt;
        // Reset for 3 cycles, then the FETCH request with no strobes.
        do_reset(3);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd1);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_ir_write", 32'(ir_write), 32'd0);
        check("rst_result_src", 32'(result_src), 32'd2);
        check("rst_alu_src_b", 32'(alu_src_b), 32'd2);

        // Fetch with two wait states, then an R-type instruction.
        next_opc = 7'b0110011;
        step(1'b0, 1'b0); check("fw1_ir_write", 32'(ir_write), 32'd0); check("fw1_req", 32'(mem_req), 32'd1);
        step(1'b0, 1'b0); check("fw2_pc_write", 32'(pc_write), 32'd0); check("fw2_req", 32'(mem_req), 32'd1);
        step(1'b1, 1'b0); check("fw3_ir_write", 32'(ir_write), 32'd1); check("fw3_pc_write", 32'(pc_write), 32'd1);
        step(1'b1, 1'b0); check("r_decode", 32'(state_dbg), 32'd1);
        step(1'b1, 1'b0); check("r_alu_op", 32'(alu_op), 32'd2); check("r_is_imm", 32'(is_imm), 32'd0);
        step(1'b1, 1'b0); check("r_reg_write", 32'(reg_write), 32'd1);

        // Load with one wait cycle on the data read.
        next_opc = 7'b0000011;
        step(1'b1, 1'b0); check("ld_fetch", 32'(state_dbg), 32'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0); check("ld_memadr", 32'(state_dbg), 32'd2);
        step(1'b0, 1'b0); check("ld_memread_adr", 32'(adr_src), 32'd1); check("ld_wait_state", 32'(state_dbg), 32'd3);
        step(1'b1, 1'b0); check("ld_memread2", 32'(state_dbg), 32'd3);
        step(1'b0, 1'b0); check("ld_memwb_rs", 32'(result_src), 32'd1); check("ld_memwb_rw", 32'(reg_write), 32'd1);

        // Branch taken, then not taken.
        next_opc = 7'b1100011;
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1); check("br_taken_pcw", 32'(pc_write), 32'd1);
        step(1'b1, 1'b0); step(1'b0, 1'b1);
        step(1'b1, 1'b0); check("br_not_taken_pcw", 32'(pc_write), 32'd0);

        // JALR: address, then shared JAL PC update and link writeback.
        next_opc = 7'b1100111;
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b0); check("jalr_src_a", 32'(alu_src_a), 32'd2); check("jalr_src_b", 32'(alu_src_b), 32'd1);
        step(1'b0, 1'b0); check("jalr_jal_pcw", 32'(pc_write), 32'd1);
        step(1'b0, 1'b0); check("jalr_link_rw", 32'(reg_write), 32'd1);

        // Illegal opcode 0000000.
        next_opc = 7'b0000000;
        step(1'b1, 1'b0); step(1'b0, 1'b0);
`ifdef MC_CTRL_TRAP_EN
        step(1'b1, 1'b0); check("trap_illegal", 32'(illegal), 32'd1);
        step(1'b1, 1'b1); check("trap_illegal_held", 32'(illegal), 32'd1); check("trap_no_req", 32'(mem_req), 32'd0);
        do_reset(1);
`else
        step(1'b0, 1'b0); check("nop_back_fetch", 32'(state_dbg), 32'd0); check("nop_no_rw", 32'(reg_write), 32'd0);
        check("nop_illegal", 32'(illegal), 32'd0);
`endif

        // Randomized instruction stream with wait states and occasional mid-flight resets.
        trap_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_state == S_FETCH) begin
                if ($urandom_range(0, 9) == 0) next_opc = 7'($urandom);
                else                           next_opc = legal_ops[$urandom_range(0, 8)];
            end
            step(1'($urandom_range(0, 9) < 6), 1'($urandom));
            trap_cnt = (m_state == S_TRAP) ? trap_cnt + 1 : 0;
            if (trap_cnt > 3 || $urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(1, 3));
                trap_cnt = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
